// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit path: FSM states, register map
// offsets and the status-to-credit decode.
package spart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_POLL_A,
    ST_POLL_W,
    ST_WR_A,
    ST_WR_D
  } spart_state_e;

  localparam logic [31:0] SPART_DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] SPART_DIV_OFS    = 32'h0000_0004;
  localparam logic [31:0] SPART_STATUS_OFS = 32'h0000_0008;

  localparam logic [7:0] SPART_NEWLINE    = 8'h0A;
  localparam logic [3:0] SPART_CREDIT_MAX = 4'd8;

  // The transmit FIFO never reports more than 8 free slots; clamp anyway so a
  // corrupt status word cannot inflate the credit.
  function automatic logic [3:0] credit_from_status(input logic [7:0] status);
    return (status[7:4] > SPART_CREDIT_MAX) ? SPART_CREDIT_MAX : status[7:4];
  endfunction

endpackage

// File: rtl/spart_rr_lock.sv
// Two-way round-robin selector with a line lock: once a requester sends a byte
// it keeps the SPART until it sends a newline or stays silent for LOCK_TIMEOUT.
module spart_rr_lock
  import spart_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       arb_en,
  input  logic       take,
  input  logic       accept,
  input  logic       accept_newline,
  output logic       sel_valid,
  output logic       sel_idx,
  output logic       owner,
  output logic       locked
);

  localparam logic [7:0] TMO_LAST = 8'(LOCK_TIMEOUT - 1);

  logic       last_q;
  logic       lock_q;
  logic [7:0] tmo_q;
  logic       owner_idle;
  logic       tmo_hit;

  assign owner  = last_q;
  assign locked = lock_q;

  // While locked only the owner is eligible; otherwise the requester that did
  // not go last has priority.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = last_q;
    if (lock_q) begin
      sel_valid = req_valid[last_q];
    end else if (req_valid[!last_q]) begin
      sel_valid = 1'b1;
      sel_idx   = !last_q;
    end else if (req_valid[last_q]) begin
      sel_valid = 1'b1;
    end
  end

  assign owner_idle = arb_en && lock_q && !req_valid[last_q];
  assign tmo_hit    = owner_idle && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      lock_q <= 1'b0;
      tmo_q  <= 8'd0;
    end else begin
      if (take) begin
        last_q <= sel_idx;
      end
      if (accept) begin
        lock_q <= !accept_newline;
        tmo_q  <= 8'd0;
      end else if (tmo_hit) begin
        lock_q <= 1'b0;
        tmo_q  <= 8'd0;
      end else if (owner_idle) begin
        tmo_q <= tmo_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spart_tx_arbiter.sv
// Shares one SPART transmitter between two cores: polls the status register
// for FIFO credit, then writes one byte per bus transaction for the owner.
module spart_tx_arbiter
  import spart_pkg::*;
#(
  parameter logic [31:0] SPART_BASE   = 32'h00F0_0000,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req_data_i,
  output logic [1:0]  req_ready_o,
  output logic        bus_req_o,
  input  logic        bus_grant_i,
  output logic [31:0] bus_addrData_o,
  output logic [3:0]  bus_byteEnables_o,
  output logic [7:0]  bus_burstSize_o,
  output logic        bus_readNWrite_o,
  output logic        bus_beginTransaction_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  input  logic [31:0] bus_addrData_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  input  logic        bus_busy_i,
  input  logic        bus_error_i
);

  spart_state_e state_q, state_d;
  logic [3:0]   credit_q, credit_d;
  logic         grant_lost_q;
  logic [7:0]   wr_byte;
  logic         lost;
  logic         take;
  logic         accept;
  logic         sel_valid;
  logic         sel_idx;
  logic         owner;
  logic         locked;
  logic [1:0]   ready_raw;
  logic         unused_rdata;

  assign unused_rdata      = ^bus_addrData_i[31:8];
  assign bus_byteEnables_o = 4'h1;
  assign bus_burstSize_o   = 8'd0;
  assign bus_req_o         = !rst && ((state_q != ST_IDLE) || (|req_valid_i));
  assign req_ready_o       = rst ? 2'b00 : ready_raw;
  assign lost              = grant_lost_q || !bus_grant_i;

  spart_rr_lock #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_rr_lock (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid_i),
    .arb_en        (state_q == ST_ARB),
    .take          (take),
    .accept        (accept),
    .accept_newline(wr_byte == SPART_NEWLINE),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx),
    .owner         (owner),
    .locked        (locked)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    credit_d               = credit_q;
    take                   = 1'b0;
    accept                 = 1'b0;
    ready_raw              = 2'b00;
    bus_addrData_o         = 32'h0;
    bus_readNWrite_o       = 1'b0;
    bus_beginTransaction_o = 1'b0;
    bus_endTransaction_o   = 1'b0;
    bus_dataValid_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req_valid_i) && bus_grant_i) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!bus_grant_i) begin
          state_d = ST_IDLE;
        end else if (sel_valid) begin
          take    = 1'b1;
          state_d = (credit_q == 4'd0) ? ST_POLL_A : ST_WR_A;
        end else if (!locked && !(|req_valid_i)) begin
          state_d = ST_IDLE;
        end
      end
      ST_POLL_A: begin
        bus_beginTransaction_o = 1'b1;
        bus_readNWrite_o       = 1'b1;
        bus_addrData_o         = SPART_BASE + SPART_STATUS_OFS;
        if (!bus_busy_i) state_d = ST_POLL_W;
      end
      ST_POLL_W: begin
        if (bus_error_i) begin
          credit_d = 4'd0;
          state_d  = lost ? ST_IDLE : ST_POLL_A;
        end else if (bus_dataValid_i) begin
          credit_d = credit_from_status(bus_addrData_i[7:0]);
          if (lost)                  state_d = ST_IDLE;
          else if (credit_d == 4'd0) state_d = ST_POLL_A;
          else                       state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        bus_beginTransaction_o = 1'b1;
        bus_addrData_o         = SPART_BASE + SPART_DATA_OFS;
        if (!bus_busy_i) state_d = ST_WR_D;
      end
      ST_WR_D: begin
        bus_addrData_o       = {24'h0, wr_byte};
        bus_dataValid_o      = 1'b1;
        bus_endTransaction_o = 1'b1;
        // An errored write is not acknowledged; the same byte is rewritten
        // after a fresh status poll.
        if (bus_error_i) begin
          credit_d = 4'd0;
          state_d  = lost ? ST_IDLE : ST_POLL_A;
        end else if (bus_endTransaction_i) begin
          accept    = 1'b1;
          ready_raw = owner ? 2'b10 : 2'b01;
          credit_d  = (credit_q != 4'd0) ? credit_q - 4'd1 : 4'd0;
          state_d   = lost ? ST_IDLE : ST_ARB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q     <= 4'd0;
      grant_lost_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      if (state_d == ST_IDLE) begin
        grant_lost_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && (state_q != ST_ARB) && !bus_grant_i) begin
        grant_lost_q <= 1'b1;
      end
    end
  end

  // Byte captured at grant time so the bus sees a stable value for the whole write.
  always_ff @(posedge clk) begin
    if (take) begin
      wr_byte <= sel_idx ? req_data_i[15:8] : req_data_i[7:0];
    end
  end

endmodule
